// File: rtl/iobuffer_sampler_pkg.sv
// Shared state encoding, event record layout and edge polarity constants
// for the IO buffer receive-side sampler and its capture FIFO.
package iobuffer_sampler_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    RUN    = ST_RUN
  } state_e;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  // Event record is {polarity, timestamp}.
  function automatic int ev_width(input int ts_w);
    return 1 + ts_w;
  endfunction

endpackage

// File: rtl/iobuffer_evfifo.sv
// Synchronous DEPTH x W event FIFO; a push into a full FIFO only lands when
// a pop happens in the same cycle. Head data reads as zero while empty.
module iobuffer_evfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // When full, the write slot is the head being popped this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/iobuffer_sampler.sv
// Receive-side pin sampler: synchronise, blank while the buffer direction
// settles, glitch-filter, and queue timestamped edge events.
//
//   state  | meaning
//   IDLE   | monitoring off, level held, filter counter cleared
//   SETTLE | direction settling, sampling blanked for SETTLE_CYCLES
//   RUN    | filtering s into level, emitting edge events
module iobuffer_sampler
  import iobuffer_sampler_pkg::*;
#(
  parameter int FILT_W        = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int DEPTH         = 4,
  parameter int TS_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pin_in,
  input  logic              mon_en,
  input  logic [FILT_W-1:0] filt_len,
  output logic              level,
  output logic              rise,
  output logic              fall,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_edge,
  output logic [TS_W-1:0]   ev_time,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int EV_W = ev_width(TS_W);
  localparam int SW   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]     SETTLE_ONE  = SW'(1);
  localparam logic [FILT_W-1:0] CNT_ONE     = FILT_W'(1);
  localparam logic [TS_W-1:0]   TS_ONE      = TS_W'(1);

  logic              sync_q;
  logic              s;
  logic [TS_W-1:0]   ts;
  state_e            state, state_nx;
  logic [SW-1:0]     settle_cnt, settle_nx;
  logic [FILT_W-1:0] cnt, cnt_nx;
  logic              level_nx, rise_nx, fall_nx;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [EV_W-1:0]   push_data, head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
      ts     <= '0;
    end else begin
      sync_q <= pin_in;
      s      <= sync_q;
      ts     <= ts + TS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
      cnt        <= cnt_nx;
      level      <= level_nx;
      rise       <= rise_nx;
      fall       <= fall_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    cnt_nx    = cnt;
    level_nx  = level;
    rise_nx   = 1'b0;
    fall_nx   = 1'b0;
    push      = 1'b0;
    if (!mon_en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx  = SETTLE;
          settle_nx = SETTLE_LOAD;
          cnt_nx    = '0;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            level_nx = s;
            state_nx = RUN;
          end else begin
            settle_nx = settle_cnt - SETTLE_ONE;
          end
        end
        RUN: begin
          // Equality compare: lowering filt_len below cnt waits for wrap.
          if (s != level) begin
            if (cnt == filt_len) begin
              level_nx = s;
              cnt_nx   = '0;
              rise_nx  = s;
              fall_nx  = !s;
              push     = 1'b1;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign push_data = {(s ? EDGE_RISE : EDGE_FALL), ts};
  assign pop       = ev_ready && !fifo_empty;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  iobuffer_evfifo #(
    .DEPTH (DEPTH),
    .W     (EV_W)
  ) u_evfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_edge  = head[EV_W-1];
  assign ev_time  = head[TS_W-1:0];

endmodule

// File: tb/tb_iobuffer_sampler.sv
// Bench for iobuffer_sampler: directed scenarios plus random pin activity,
// compared every cycle against a behavioural model and an event scoreboard.
module tb_iobuffer_sampler;

  localparam int FILT_W        = 4;
  localparam int SETTLE_CYCLES = 8;
  localparam int DEPTH         = 4;
  localparam int TS_W          = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pin_in;
  logic              mon_en;
  logic [FILT_W-1:0] filt_len;
  logic              level, rise, fall;
  logic              ev_valid, ev_ready, ev_edge;
  logic [TS_W-1:0]   ev_time;
  logic              overflow, ovf_clr;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic m_s1 = 1'b0, m_s = 1'b0, m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_ovf = 1'b0;
  int   m_ts = 0, m_mode = 0, m_settle = 0, m_run = 0, m_cnt = 0;
  logic [TS_W:0] sb_q[$];

  iobuffer_sampler #(
    .FILT_W        (FILT_W),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .DEPTH         (DEPTH),
    .TS_W          (TS_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin_in   (pin_in),
    .mon_en   (mon_en),
    .filt_len (filt_len),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_edge  (ev_edge),
    .ev_time  (ev_time),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: mode 0 = off, 1 = blanking, 2 = filtering.
  initial forever begin
    logic pop, acc, pol, drop;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = 0; m_s = 0; m_level = 0; m_rise = 0; m_fall = 0; m_ovf = 0;
      m_ts = 0; m_mode = 0; m_settle = 0; m_run = 0; m_cnt = 0;
      sb_q.delete();
    end else begin
      pop = ev_ready && (m_cnt > 0);
      acc = 0; pol = 0; drop = 0;
      if (!mon_en) begin
        m_mode = 0;
        m_run  = 0;
      end else if (m_mode == 0) begin
        m_mode   = 1;
        m_settle = SETTLE_CYCLES - 1;
      end else if (m_mode == 1) begin
        if (m_settle == 0) begin
          m_level = m_s;
          m_mode  = 2;
        end else m_settle--;
      end else if (m_s != m_level) begin
        if (m_run == int'(filt_len)) begin
          acc = 1; pol = m_s; m_level = m_s; m_run = 0;
        end else m_run = (m_run + 1) % (1 << FILT_W);
      end else m_run = 0;
      m_rise = acc && pol;
      m_fall = acc && !pol;
      if (acc) begin
        if (m_cnt < DEPTH || pop) begin
          sb_q.push_back({pol, TS_W'(m_ts)});
          m_cnt++;
        end else drop = 1;
      end
      if (pop) m_cnt--;
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_ts = (m_ts + 1) % (1 << TS_W);
      m_s  = m_s1;
      m_s1 = pin_in;
    end
  end

  // Monitor: per-cycle output compare plus scoreboard pop on handshake.
  initial forever begin
    logic [TS_W:0] exp_ev;
    @(negedge clk);
    chk("level", 32'(level), 32'(m_level));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("ev_valid", 32'(ev_valid), 32'(m_cnt > 0));
    if (ev_valid && ev_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_pop: got event %0d/%0h expected none at %0t", ev_edge, ev_time, $time);
      end else begin
        exp_ev = sb_q.pop_front();
        chk("ev_edge", 32'(ev_edge), 32'(exp_ev[TS_W]));
        chk("ev_time", 32'(ev_time), 32'(exp_ev[TS_W-1:0]));
      end
    end
  end

  initial begin
    pin_in = 0; mon_en = 0; filt_len = '0; ev_ready = 0; ovf_clr = 0;
    repeat (3) tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_rise", 32'(rise), 0);
    chk("rst_fall", 32'(fall), 0);
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_ev_edge", 32'(ev_edge), 0);
    chk("rst_ev_time", 32'(ev_time), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1;
    pin_in = 1;
    repeat (3) tick();

    // Settle: level follows the pin exactly 8 cycles after entering SETTLE.
    mon_en = 1;
    repeat (8) tick();
    chk("settle_early", 32'(level), 0);
    tick();
    chk("settle_done", 32'(level), 1);
    chk("settle_no_rise", 32'(rise), 0);
    chk("settle_no_event", 32'(ev_valid), 0);

    // filt_len = 0: fall two edges after the pin is sampled.
    pin_in = 0;
    tick();
    tick();
    chk("fall_not_yet", 32'(level), 1);
    tick();
    chk("fall_pulse", 32'(fall), 1);
    chk("fall_level", 32'(level), 0);
    chk("fall_valid", 32'(ev_valid), 1);
    chk("fall_edge", 32'(ev_edge), 0);
    chk("fall_time", 32'(ev_time), 32'((m_ts + (1 << TS_W) - 1) % (1 << TS_W)));
    ev_ready = 1; tick(); ev_ready = 0;

    // filt_len = 3: 3-sample glitch rejected, 4-sample low accepted.
    filt_len = 4'd3;
    pin_in = 1;
    repeat (8) tick();
    ev_ready = 1; tick(); ev_ready = 0;
    pin_in = 0;
    repeat (3) tick();
    pin_in = 1;
    repeat (8) tick();
    chk("glitch_level", 32'(level), 1);
    chk("glitch_no_event", 32'(ev_valid), 0);
    pin_in = 0;
    repeat (8) tick();
    chk("filt_level", 32'(level), 0);
    chk("filt_event", 32'(ev_valid), 1);
    ev_ready = 1; tick(); ev_ready = 0;

    // Five edges into a depth-4 FIFO with no consumer.
    filt_len = '0;
    for (int k = 0; k < 5; k++) begin
      pin_in = ~pin_in;
      repeat (4) tick();
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_valid", 32'(ev_valid), 1);
    ovf_clr = 1; tick(); ovf_clr = 0; tick();
    chk("ovf_clear", 32'(overflow), 0);
    ev_ready = 1; repeat (6) tick(); ev_ready = 0;
    chk("drain_empty", 32'(ev_valid), 0);

    // Full FIFO, edge accepted in the same cycle as a pop.
    for (int k = 0; k < 4; k++) begin
      pin_in = ~pin_in;
      repeat (4) tick();
    end
    pin_in = ~pin_in;
    tick();
    tick();
    ev_ready = 1; tick(); ev_ready = 0;
    tick();
    chk("full_pop_no_ovf", 32'(overflow), 0);
    chk("full_pop_valid", 32'(ev_valid), 1);
    ev_ready = 1; repeat (7) tick(); ev_ready = 0;

    // Random activity, including timestamp wraps and mon_en toggles.
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 4) == 0) pin_in = ~pin_in;
      ev_ready = ($urandom_range(0, 1) == 1);
      ovf_clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) filt_len = FILT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 149) == 0) mon_en = ~mon_en;
      else if (!mon_en && $urandom_range(0, 9) == 0) mon_en = 1;
    end

    // Reset while events are queued.
    mon_en = 1; filt_len = '0; ev_ready = 0; ovf_clr = 0;
    repeat (12) tick();
    for (int k = 0; k < 3; k++) begin
      pin_in = ~pin_in;
      repeat (4) tick();
    end
    chk("pre_rst_valid", 32'(ev_valid), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(ev_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ($urandom_range(0, 5) == 0) pin_in = ~pin_in;
    end
    ev_ready = 1;
    repeat (10) tick();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
